// File: rtl/conv_pkg.sv
// conv_pkg: shared types and default widths for the conv group scheduler.
//   sched_state_e    scheduler FSM state encoding
//   Def*             default parameter values for the scheduler and its watchdog
//   CiGroupsWidth    fixed width of the input-channel-group count / weight stride
package conv_pkg;

    localparam int unsigned DefWtAddrWidth   = 12;
    localparam int unsigned DefBiasGroupBits = 7;
    localparam int unsigned DefWdogWidth     = 24;
    localparam int unsigned CiGroupsWidth    = 10;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StRun,
        StNext,
        StFin
    } sched_state_e;

endpackage

// File: rtl/sched_wdog.sv
// sched_wdog: per-group watchdog for conv_group_sched.
//   clk, rst   clock and synchronous active-low reset
//   clear      zero the counter (scheduler is issuing a new group)
//   count_en   count this cycle (scheduler is waiting on a group)
//   limit      cycle budget per group; 0 disables expiry
//   expired    combinational: the current counting cycle is the last one allowed
module sched_wdog
    import conv_pkg::*;
#(
    parameter int unsigned Width = DefWdogWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             count_en,
    input  logic [Width-1:0] limit,
    output logic             expired
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (count_en) begin
            cnt_q <= cnt_q + Width'(1);
        end
    end

    // Fires during the limit-th counting cycle, so the scheduler leaves RUN after exactly
    // limit cycles there.
    assign expired = count_en && (limit != '0) && (cnt_q == limit - Width'(1));

endmodule

// File: rtl/conv_group_sched.sv
// conv_group_sched: steps a conv engine through the output-channel groups of a layer,
// replaying the input feature map via DMA for each group.
//   clk, rst             clock, synchronous active-low reset
//   cfg_*                layer configuration, latched on an accepted start
//   start, abort         layer start pulse / cancel
//   busy, done, aborted  status: layer active, completion pulse, cancel/watchdog pulse
//   cur_group            group currently being processed
//   conv_go, conv_*      start pulse and per-group configuration to the conv engine
//   conv_busy, conv_done conv engine status
//   dma_start/ready/done feature-map replay request handshake and completion
// Build option: define CONV_GROUP_SCHED_WDOG_EN to add a per-group watchdog that aborts the
// layer when a group spends cfg_wdog_limit cycles in RUN.
module conv_group_sched
    import conv_pkg::*;
#(
    parameter int unsigned WT_ADDR_WIDTH   = DefWtAddrWidth,
    parameter int unsigned BIAS_GROUP_BITS = DefBiasGroupBits,
    parameter int unsigned WDOG_WIDTH      = DefWdogWidth
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BIAS_GROUP_BITS:0]   cfg_co_groups,
    input  logic [CiGroupsWidth-1:0]   cfg_ci_groups,
    input  logic [WT_ADDR_WIDTH-1:0]   cfg_wt_base_addr,
    input  logic [WDOG_WIDTH-1:0]      cfg_wdog_limit,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic                       aborted,
    output logic [BIAS_GROUP_BITS-1:0] cur_group,
    output logic                       conv_go,
    output logic [BIAS_GROUP_BITS-1:0] conv_output_group,
    output logic [WT_ADDR_WIDTH-1:0]   conv_wt_base_addr,
    input  logic                       conv_busy,
    input  logic                       conv_done,
    output logic                       dma_start,
    input  logic                       dma_ready,
    input  logic                       dma_done
);

    sched_state_e               state_q;
    logic [BIAS_GROUP_BITS:0]   co_q;
    logic [CiGroupsWidth-1:0]   ci_q;
    logic [BIAS_GROUP_BITS-1:0] group_q;
    logic [WT_ADDR_WIDTH-1:0]   wt_base_q;
    logic                       conv_flag_q, dma_flag_q;
    logic                       busy_q, done_q, aborted_q, conv_go_q, dma_start_q;

    logic [BIAS_GROUP_BITS:0]   last_group;
    logic                       is_last;
    logic [WT_ADDR_WIDTH-1:0]   wt_stride;
    logic                       wdog_expired;
    logic                       kill;

    assign last_group = co_q - (BIAS_GROUP_BITS + 1)'(1);
    assign is_last    = ({1'b0, group_q} == last_group);
    assign wt_stride  = WT_ADDR_WIDTH'(ci_q);

`ifdef CONV_GROUP_SCHED_WDOG_EN
    logic [WDOG_WIDTH-1:0] wdog_limit_q;
    logic                  wdog_clear, wdog_count;

    assign wdog_clear = (state_q == StIssue);
    assign wdog_count = (state_q == StRun);

    sched_wdog #(
        .Width (WDOG_WIDTH)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (wdog_clear),
        .count_en (wdog_count),
        .limit    (wdog_limit_q),
        .expired  (wdog_expired)
    );
`else
    logic unused_wdog_limit;
    assign unused_wdog_limit = ^cfg_wdog_limit;
    assign wdog_expired      = 1'b0;
`endif

    assign kill = abort || wdog_expired;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            co_q        <= '0;
            ci_q        <= '0;
            group_q     <= '0;
            wt_base_q   <= '0;
            conv_flag_q <= 1'b0;
            dma_flag_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            conv_go_q   <= 1'b0;
            dma_start_q <= 1'b0;
`ifdef CONV_GROUP_SCHED_WDOG_EN
            wdog_limit_q <= '0;
`endif
        end else begin
            // Pulses default low; the request drops the cycle after it is accepted.
            conv_go_q <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            if (dma_start_q && dma_ready) begin
                dma_start_q <= 1'b0;
            end

            if (state_q != StIdle && kill) begin
                // Cancel wins over any completion or start seen this cycle.
                state_q     <= StIdle;
                busy_q      <= 1'b0;
                aborted_q   <= 1'b1;
                dma_start_q <= 1'b0;
                conv_flag_q <= 1'b0;
                dma_flag_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start && !abort) begin
                            co_q        <= cfg_co_groups;
                            ci_q        <= cfg_ci_groups;
                            group_q     <= '0;
                            wt_base_q   <= cfg_wt_base_addr;
                            conv_flag_q <= 1'b0;
                            dma_flag_q  <= 1'b0;
                            busy_q      <= 1'b1;
`ifdef CONV_GROUP_SCHED_WDOG_EN
                            wdog_limit_q <= cfg_wdog_limit;
`endif
                            state_q     <= (cfg_co_groups == '0) ? StFin : StIssue;
                        end
                    end
                    StIssue: begin
                        if (!conv_busy) begin
                            conv_go_q   <= 1'b1;
                            dma_start_q <= 1'b1;
                            state_q     <= StRun;
                        end
                    end
                    StRun: begin
                        if (conv_done) conv_flag_q <= 1'b1;
                        if (dma_done)  dma_flag_q  <= 1'b1;
                        // dma_start is low in RUN only once the request was accepted.
                        if (conv_flag_q && dma_flag_q && !dma_start_q) begin
                            state_q <= StNext;
                        end
                    end
                    StNext: begin
                        if (is_last) begin
                            state_q <= StFin;
                        end else begin
                            group_q     <= group_q + BIAS_GROUP_BITS'(1);
                            wt_base_q   <= wt_base_q + wt_stride;
                            conv_flag_q <= 1'b0;
                            dma_flag_q  <= 1'b0;
                            state_q     <= StIssue;
                        end
                    end
                    StFin: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign aborted           = aborted_q;
    assign cur_group         = group_q;
    assign conv_go           = conv_go_q;
    assign conv_output_group = group_q;
    assign conv_wt_base_addr = wt_base_q;
    assign dma_start         = dma_start_q;

endmodule

// File: tb/tb_conv_group_sched.sv
// tb_conv_group_sched: directed, self-checking bench for conv_group_sched.
// Inputs are driven and outputs sampled on the falling clock edge.
// With CONV_GROUP_SCHED_WDOG_EN defined the watchdog expiry is exercised; otherwise the
// limit input is shown to be ignored.
module tb_conv_group_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  cfg_co_groups = '0;
    logic [9:0]  cfg_ci_groups = '0;
    logic [11:0] cfg_wt_base_addr = '0;
    logic [23:0] cfg_wdog_limit = '0;
    logic        start = 1'b0, abort = 1'b0;
    logic        busy, done, aborted, conv_go, dma_start;
    logic [6:0]  cur_group, conv_output_group;
    logic [11:0] conv_wt_base_addr;
    logic        conv_busy = 1'b0, conv_done = 1'b0;
    logic        dma_ready = 1'b1, dma_done = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_group_sched dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_co_groups     (cfg_co_groups),
        .cfg_ci_groups     (cfg_ci_groups),
        .cfg_wt_base_addr  (cfg_wt_base_addr),
        .cfg_wdog_limit    (cfg_wdog_limit),
        .start             (start),
        .abort             (abort),
        .busy              (busy),
        .done              (done),
        .aborted           (aborted),
        .cur_group         (cur_group),
        .conv_go           (conv_go),
        .conv_output_group (conv_output_group),
        .conv_wt_base_addr (conv_wt_base_addr),
        .conv_busy         (conv_busy),
        .conv_done         (conv_done),
        .dma_start         (dma_start),
        .dma_ready         (dma_ready),
        .dma_done          (dma_done)
    );

    typedef struct {
        int unsigned co;
        int unsigned ci;
        int unsigned base;
        int unsigned exp_base[4];
    } layer_t;

    layer_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge; single-cycle pulse inputs fall back to 0.
    task automatic tick();
        @(negedge clk);
        start     = 1'b0;
        abort     = 1'b0;
        conv_done = 1'b0;
        dma_done  = 1'b0;
    endtask

    task automatic set_cfg(input int unsigned co, input int unsigned ci, input int unsigned base);
        cfg_co_groups    = 8'(co);
        cfg_ci_groups    = 10'(ci);
        cfg_wt_base_addr = 12'(base);
    endtask

    task automatic wait_go(input string name, input int bound, output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!conv_go && waited < bound);
        check({name, "_go_seen"}, 32'(conv_go), 32'd1);
    endtask

    task automatic wait_done(input string name, input int bound, output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!done && waited < bound);
        check({name, "_done_seen"}, 32'(done), 32'd1);
    endtask

    // Runs one layer with an always-ready DMA and immediate completions.
    task automatic run_layer(input layer_t v, input string tag);
        int cyc = 0;
        int go_n = 0;
        int last_go = 0;
        int done_at = -1;
        bit dma_seen = 1'b0;
        set_cfg(v.co, v.ci, v.base);
        dma_ready = 1'b1;
        start = 1'b1;
        while (done_at < 0 && cyc < 100) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                check({tag, "_busy"}, 32'(busy), 32'd1);
                set_cfg(0, 7, 'h5a5);  // latched copy must be used from here on
            end
            if (dma_start) dma_seen = 1'b1;
            if (conv_go) begin
                if (go_n == 0) check({tag, "_go_latency"}, cyc, 2);
                else           check({tag, "_go_gap"}, cyc - last_go, 4);
                check({tag, "_group"}, 32'(conv_output_group), go_n);
                check({tag, "_cur_group"}, 32'(cur_group), go_n);
                check({tag, "_wt_base"}, 32'(conv_wt_base_addr),
                      (go_n < 4) ? v.exp_base[go_n] : 32'hffff);
                check({tag, "_dma_with_go"}, 32'(dma_start), 32'd1);
                last_go   = cyc;
                go_n++;
                conv_done = 1'b1;
                dma_done  = 1'b1;
            end
            if (done) done_at = cyc;
        end
        check({tag, "_go_count"}, go_n, v.co);
        check({tag, "_done_at"}, done_at, (v.co == 0) ? 2 : last_go + 4);
        check({tag, "_dma_seen"}, 32'(dma_seen), (v.co != 0) ? 32'd1 : 32'd0);
        tick();
        check({tag, "_done_width"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int w;
        int n;
        int hi;
        int pulses;

        tbl[0] = '{3, 4, 'h010, '{'h010, 'h014, 'h018, 0}};
        tbl[1] = '{2, 3, 'hffe, '{'hffe, 'h001, 0, 0}};
        tbl[2] = '{1, 0, 'h123, '{'h123, 0, 0, 0}};
        tbl[3] = '{4, 'h3ff, 'h800, '{'h800, 'hbff, 'hffe, 'h3fd}};
        tbl[4] = '{0, 5, 'h040, '{0, 0, 0, 0}};

        // Reset state
        rst = 1'b0;
        set_cfg(3, 4, 'h010);
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_aborted", 32'(aborted), 0);
        check("rst_conv_go", 32'(conv_go), 0);
        check("rst_dma_start", 32'(dma_start), 0);
        check("rst_cur_group", 32'(cur_group), 0);
        check("rst_out_group", 32'(conv_output_group), 0);
        check("rst_wt_base", 32'(conv_wt_base_addr), 0);
        start = 1'b0;
        rst = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_layer(tbl[i], $sformatf("layer%0d", i));
        end

        // DMA back-pressure and completion ordering
        set_cfg(3, 1, 'h000);
        dma_ready = 1'b0;
        start = 1'b1;
        wait_go("bp_g0", 10, w);
        hi = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) check("bp_dma_drop", 32'(dma_start), 0);
            if (dma_start) hi++;
            dma_ready = (i == 5);
            dma_done  = (i == 1);
            conv_done = (i == 3);
            tick();
        end
        check("bp_dma_held", hi, 6);
        dma_ready = 1'b1;
        wait_go("bp_g1", 10, w);
        check("bp_g1_gap", w, 2);
        check("bp_g1_base", 32'(conv_wt_base_addr), 'h001);
        conv_done = 1'b1;
        tick();
        dma_done = 1'b1;
        wait_go("bp_g2", 10, w);
        check("bp_g2_gap", w, 4);
        check("bp_g2_group", 32'(cur_group), 2);
        conv_done = 1'b1;
        dma_done  = 1'b1;
        wait_done("bp_fin", 20, w);
        check("bp_done_lat", w, 4);

        // Abort in RUN of group 1, together with conv_done; start ignored while busy
        set_cfg(3, 4, 'h010);
        start = 1'b1;
        wait_go("ab_g0", 10, w);
        start = 1'b1;
        cfg_ci_groups = 10'd9;
        cfg_wt_base_addr = 12'h700;
        conv_done = 1'b1;
        dma_done  = 1'b1;
        tick();
        dma_ready = 1'b0;
        wait_go("ab_g1", 10, w);
        check("ab_g1_base", 32'(conv_wt_base_addr), 'h014);
        check("ab_g1_group", 32'(cur_group), 1);
        tick();
        check("ab_dma_pending", 32'(dma_start), 1);
        abort = 1'b1;
        conv_done = 1'b1;
        tick();
        check("ab_aborted", 32'(aborted), 1);
        check("ab_idle", 32'(busy), 0);
        check("ab_dma_drop", 32'(dma_start), 0);
        check("ab_no_done", 32'(done), 0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            pulses += int'(done) + int'(aborted) + int'(conv_go);
        end
        check("ab_quiet", pulses, 0);
        dma_ready = 1'b1;
        set_cfg(3, 4, 'h010);
        start = 1'b1;
        wait_go("ab_restart", 10, w);
        check("ab_restart_lat", w, 2);
        check("ab_restart_group", 32'(conv_output_group), 0);
        check("ab_restart_base", 32'(conv_wt_base_addr), 'h010);
        tick();
        abort = 1'b1;
        tick();
        check("ab2_aborted", 32'(aborted), 1);

        // conv engine busy delays issue; config is already stable before conv_go
        set_cfg(1, 2, 'h055);
        conv_busy = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("cb_no_go", 32'(conv_go), 0);
            check("cb_base_early", 32'(conv_wt_base_addr), 'h055);
        end
        conv_busy = 1'b0;
        wait_go("cb", 10, w);
        check("cb_go_lat", w, 1);
        conv_done = 1'b1;
        dma_done  = 1'b1;
        wait_done("cb_fin", 20, w);
        check("cb_done_lat", w, 4);

        // Reset mid-layer discards progress silently
        set_cfg(3, 1, 'h200);
        start = 1'b1;
        wait_go("rm_g0", 10, w);
        conv_done = 1'b1;
        dma_done  = 1'b1;
        wait_go("rm_g1", 10, w);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rm_busy", 32'(busy), 0);
        check("rm_group", 32'(cur_group), 0);
        check("rm_base", 32'(conv_wt_base_addr), 0);
        pulses = int'(done) + int'(aborted);
        for (int i = 0; i < 6; i++) begin
            tick();
            pulses += int'(done) + int'(aborted) + int'(conv_go) + int'(dma_start);
        end
        check("rm_quiet", pulses, 0);

`ifdef CONV_GROUP_SCHED_WDOG_EN
        // Watchdog: conv_done withheld, limit 100
        set_cfg(2, 1, 'h000);
        cfg_wdog_limit = 24'd100;
        start = 1'b1;
        wait_go("wd", 10, w);
        dma_done = 1'b1;
        n = 0;
        while (!aborted && n < 300) begin
            tick();
            n++;
        end
        check("wd_abort_at", n, 100);
        check("wd_idle", 32'(busy), 0);
        check("wd_no_done", 32'(done), 0);
        cfg_wdog_limit = '0;
`else
        // Without the watchdog the limit is ignored
        set_cfg(2, 1, 'h000);
        cfg_wdog_limit = 24'd5;
        start = 1'b1;
        wait_go("nwd", 10, w);
        dma_done = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            pulses += int'(aborted);
        end
        check("nwd_no_abort", pulses, 0);
        check("nwd_still_busy", 32'(busy), 1);
        abort = 1'b1;
        tick();
        check("nwd_abort", 32'(aborted), 1);
        cfg_wdog_limit = '0;
`endif
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/conv_group_sched.md
CONV_GROUP_SCHED -- requirements
Module: conv_group_sched

Interface
REQ-001 Parameter WT_ADDR_WIDTH, default 12: width of weight-store addresses.
REQ-002 Parameter BIAS_GROUP_BITS, default 7: width of the output-group index.
REQ-003 Parameter WDOG_WIDTH, default 24: width of the watchdog counter and limit.
REQ-004 Ports SHALL be:
  clk  in  1  sole clock
  rst  in  1  synchronous, active-low reset
  cfg_co_groups  in  BIAS_GROUP_BITS+1  number of output-channel groups in the layer
  cfg_ci_groups  in  10  input-channel groups, which is also the weight-address stride per output group
  cfg_wt_base_addr  in  WT_ADDR_WIDTH  weight address of group 0
  cfg_wdog_limit  in  WDOG_WIDTH  maximum cycles per group (watchdog build only)
  start  in  1  layer-start pulse
  abort  in  1  cancel the layer
  busy  out  1  layer in progress
  done  out  1  one-cycle pulse when the layer completes
  aborted  out  1  one-cycle pulse on abort or watchdog expiry
  cur_group  out  BIAS_GROUP_BITS  group currently being processed
  conv_go  out  1  one-cycle start pulse to the conv engine
  conv_output_group  out  BIAS_GROUP_BITS  output-group configuration to the conv engine
  conv_wt_base_addr  out  WT_ADDR_WIDTH  weight-base configuration to the conv engine
  conv_busy  in  1  conv engine is active
  conv_done  in  1  conv engine finished a group
  dma_start  out  1  request to replay the input feature map (valid)
  dma_ready  in  1  DMA accepts the request
  dma_done  in  1  pixel replay is complete

Function
REQ-005 States SHALL be IDLE, ISSUE, RUN, NEXT and FIN, all registered.
REQ-006 In IDLE with start=1 and abort=0, the block SHALL latch all cfg_* inputs, set group=0, set the weight base to cfg_wt_base_addr, and go to ISSUE (or to FIN if cfg_co_groups=0).
REQ-007 start SHALL be ignored outside IDLE.
REQ-008 In ISSUE, the block SHALL wait until conv_busy=0, then assert conv_go for exactly 1 cycle and go to RUN.
REQ-009 dma_start SHALL be asserted in the same cycle as conv_go and held until sampled with dma_ready=1; it SHALL drop in the cycle after acceptance.
REQ-010 conv_output_group and conv_wt_base_addr SHALL be stable from 1 cycle before conv_go until the group completes.
REQ-011 Sticky flags SHALL capture conv_done and dma_done in any order, including both in the same cycle; the flags SHALL clear on entry to ISSUE.
REQ-012 RUN SHALL exit to NEXT in the cycle after both flags are set and dma_start has been accepted.
REQ-013 NEXT: if group equals cfg_co_groups-1, go to FIN; otherwise group+1, weight base += cfg_ci_groups (modulo 2^WT_ADDR_WIDTH, wrap permitted), then go to ISSUE.
REQ-014 FIN SHALL pulse done for 1 cycle and return to IDLE.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 Timing: start accepted at cycle 0 with conv_busy=0 gives conv_go at cycle 2; the last completion flag set at cycle N gives done at cycle N+3.
REQ-017 abort=1 in any non-IDLE state SHALL go to IDLE next cycle, pulse aborted, deassert dma_start, and produce no done.
REQ-018 abort has priority over start, conv_done and dma_done arriving in the same cycle.
REQ-019 cur_group SHALL mirror the internal group register.

Reset
REQ-020 While rst=0 at a clock edge: state=IDLE; busy, done, aborted, conv_go and dma_start =0; cur_group, conv_output_group and conv_wt_base_addr =0; sticky flags cleared.
REQ-021 Reset mid-layer SHALL discard all progress without a done or aborted pulse.

Configuration
REQ-022 Macro CONV_GROUP_SCHED_WDOG_EN defined: a counter SHALL clear on ISSUE entry and count in RUN; reaching cfg_wdog_limit (nonzero) SHALL behave exactly as abort.
REQ-023 Macro CONV_GROUP_SCHED_WDOG_EN undefined: no counter; cfg_wdog_limit is ignored; aborted fires only on abort.

Structure
REQ-024 The state enum and default widths SHALL live in shared package conv_pkg.
REQ-025 The watchdog SHALL be sub-module sched_wdog, instantiated only when the macro is defined.

Verification
REQ-026 cfg_co_groups=3, ci_groups=4, base=0x010, immediate dma_ready, and conv_done/dma_done pulses -> conv_wt_base_addr 0x010, 0x014, 0x018 with groups 0, 1, 2, then one done pulse.
REQ-027 cfg_co_groups=0 and start -> done exactly 2 cycles later; conv_go and dma_start never assert.
REQ-028 dma_ready held low 5 cycles, dma_done before conv_done, and both in the same cycle on group 2 -> no lost completion; dma_start held 6 cycles.
REQ-029 base=0xFFE, ci_groups=3, co_groups=2 -> group-1 base 0x001 (wrap).
REQ-030 abort in RUN of group 1 together with conv_done -> aborted pulse, IDLE next cycle, no done; a following start restarts at group 0.
REQ-031 With the watchdog built, limit=100 and conv_done withheld -> aborted exactly 100 cycles into RUN.
